wb_arbiter_rr: RTL and testbench

//  Round-robin arbiter that shares one Wishbone master port among N_MASTERS requesters.

---
 rtl/wb_arbiter_pkg.sv | 22 ++
 rtl/wb_rr_picker.sv | 39 +++
 rtl/wb_arbiter_rr.sv | 196 +++++++++++++++++++
 tb/tb_wb_arbiter_rr.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
//
// Contents:
//   wb_arb_state_e : arbiter FSM states. ABORT is reachable only when
//                    WB_ARBITER_TIMEOUT_EN is defined.
//   idx_width()    : width of a requester index. It never returns less than
//                    1, so a 2-requester build still has a real index bit.
package wb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ABORT = 2'd2
    } wb_arb_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Round-robin request picker, purely combinational.
// Latency: 0 cycles (same-cycle result).
// Backpressure: none; the caller decides when to accept idx.
//
// Ports:
//   req   [N]   : request vector, one bit per requester
//   last  [IW]  : index of the previous winner; the search starts at last+1
//   valid       : at least one request is active
//   idx   [IW]  : first active requester at last+1, last+2, ... mod N
module wb_rr_picker
    import wb_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    // Scan offsets from farthest to nearest. Later matches overwrite earlier
    // ones, so the final result is the requester closest after 'last'.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % N);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter sharing one Wishbone master port among N_MASTERS requesters.
// Latency: 1 clk from a requester's CYC to the downstream CYC. The grant is
//          held for the whole CYC, with one IDLE cycle between owners.
// Backpressure: non-owners wait with ACK/ERR/DAT_R held at 0. The owner's
//               stalls come straight from the downstream ACK.
//
// Optional feature, enabled by defining WB_ARBITER_TIMEOUT_EN:
//   A stall watchdog. After TIMEOUT_CYCLES consecutive stalled cycles the
//   owner receives a one-cycle ERR. The arbiter then holds in ABORT until
//   the owner drops CYC. Without the macro, TIMEOUT_CYCLES has no effect.
//
// Ports (each m_* vector holds one element per requester, index = requester number):
//   clk, rstn                                 : clock; asynchronous, active-low reset
//   m_adr/m_cti/m_bte/m_dat_w/m_sel/m_we      : requester request fields (in)
//   m_cyc/m_stb                               : requester cycle and strobe (in)
//   m_dat_r/m_ack/m_err                       : responses to requesters (out)
//   s_adr/s_cti/s_bte/s_dat_w/s_sel/s_we      : downstream request fields (out)
//   s_cyc/s_stb                               : downstream cycle and strobe (out)
//   s_dat_r/s_ack/s_err                       : downstream responses (in)
//   gnt                                       : one-hot current owner; all-zero when idle
module wb_arbiter_rr
    import wb_arbiter_pkg::*;
#(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int N_MASTERS      = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                         clk,
    input  logic                                         rstn,
    // requester ports
    input  logic [N_MASTERS-1:0][WB_ADDR_WIDTH-1:0]      m_adr,
    input  logic [N_MASTERS-1:0][2:0]                    m_cti,
    input  logic [N_MASTERS-1:0][1:0]                    m_bte,
    input  logic [N_MASTERS-1:0][WB_DATA_WIDTH-1:0]      m_dat_w,
    output logic [N_MASTERS-1:0][WB_DATA_WIDTH-1:0]      m_dat_r,
    input  logic [N_MASTERS-1:0]                         m_cyc,
    output logic [N_MASTERS-1:0]                         m_err,
    input  logic [N_MASTERS-1:0][WB_DATA_WIDTH/8-1:0]    m_sel,
    input  logic [N_MASTERS-1:0]                         m_stb,
    output logic [N_MASTERS-1:0]                         m_ack,
    input  logic [N_MASTERS-1:0]                         m_we,
    // shared downstream port
    output logic [WB_ADDR_WIDTH-1:0]                     s_adr,
    output logic [2:0]                                   s_cti,
    output logic [1:0]                                   s_bte,
    output logic [WB_DATA_WIDTH-1:0]                     s_dat_w,
    input  logic [WB_DATA_WIDTH-1:0]                     s_dat_r,
    output logic                                         s_cyc,
    input  logic                                         s_err,
    output logic [WB_DATA_WIDTH/8-1:0]                   s_sel,
    output logic                                         s_stb,
    input  logic                                         s_ack,
    output logic                                         s_we,
    // observe
    output logic [N_MASTERS-1:0]                         gnt
);

    localparam int IW = idx_width(N_MASTERS);

    if (N_MASTERS < 2 || N_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("wb_arbiter_rr: N_MASTERS must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    wb_arb_state_e state;
    logic [IW-1:0] owner;      // binary copy of gnt, used to drive the muxes
    logic [IW-1:0] last_gnt;
    logic          pick_vld;
    logic [IW-1:0] pick_idx;
    logic          in_grant;
    logic          timeout_hit;

    assign in_grant = (state == GRANT);

    wb_rr_picker #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_picker (
        .req   (m_cyc),
        .last  (last_gnt),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    // Request mux. It is gated only by the registered state, so when rstn
    // asserts, s_cyc/s_stb fall together with state without waiting for a
    // clock edge.
    always_comb begin
        s_adr   = '0;
        s_cti   = '0;
        s_bte   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        s_we    = 1'b0;
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        if (in_grant) begin
            s_adr   = m_adr[owner];
            s_cti   = m_cti[owner];
            s_bte   = m_bte[owner];
            s_dat_w = m_dat_w[owner];
            s_sel   = m_sel[owner];
            s_we    = m_we[owner];
            s_cyc   = m_cyc[owner];
            s_stb   = m_stb[owner];
        end
    end

    // Response demux. The response is forwarded regardless of the owner's
    // CYC, so an ACK that arrives in the cycle the owner drops CYC still
    // reaches it.
    always_comb begin
        m_ack   = '0;
        m_err   = '0;
        m_dat_r = '0;
        if (in_grant) begin
            m_ack[owner]   = s_ack;
            m_err[owner]   = s_err | timeout_hit;
            m_dat_r[owner] = s_dat_r;
        end
    end

`ifdef WB_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tmo_cnt;
    logic          stalled;

    assign stalled = in_grant && s_stb && !s_ack && !s_err;

    // ERR is raised during the stalled cycle that brings the count to
    // TIMEOUT_CYCLES, not one cycle later.
    assign timeout_hit = stalled && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt <= '0;
        end else if (!in_grant || s_ack || s_err) begin
            tmo_cnt <= '0;
        end else if (stalled) begin
            tmo_cnt <= tmo_cnt + CW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Arbitration FSM. gnt, owner and last_gnt are all registered here.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            last_gnt <= IW'(N_MASTERS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state <= GRANT;
                        owner <= pick_idx;
                        gnt   <= N_MASTERS'(1) << pick_idx;
                    end
                end
                GRANT: begin
                    if (!m_cyc[owner]) begin
                        state    <= IDLE;
                        gnt      <= '0;
                        last_gnt <= owner;
                    end
`ifdef WB_ARBITER_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state <= ABORT;
                    end
`endif
                end
`ifdef WB_ARBITER_TIMEOUT_EN
                ABORT: begin
                    // The downstream port is already released. Wait for the
                    // owner to end its cycle so it cannot resume a transfer
                    // the slave no longer sees.
                    if (!m_cyc[owner]) begin
                        state    <= IDLE;
                        gnt      <= '0;
                        last_gnt <= owner;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed self-checking bench for wb_arbiter_rr (4 requesters, 32-bit bus).
// Latency: n/a.
// Backpressure: the bench acts as the slave and ACKs one cycle after a strobe.
module tb_wb_arbiter_rr;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic                      clk = 1'b0;
    logic                      rstn = 1'b0;
    logic [N-1:0][AW-1:0]      m_adr = '0;
    logic [N-1:0][2:0]         m_cti = '0;
    logic [N-1:0][1:0]         m_bte = '0;
    logic [N-1:0][DW-1:0]      m_dat_w = '0;
    logic [N-1:0][DW-1:0]      m_dat_r;
    logic [N-1:0]              m_cyc = '0;
    logic [N-1:0]              m_err;
    logic [N-1:0][DW/8-1:0]    m_sel = '0;
    logic [N-1:0]              m_stb = '0;
    logic [N-1:0]              m_ack;
    logic [N-1:0]              m_we = '0;
    logic [AW-1:0]             s_adr;
    logic [2:0]                s_cti;
    logic [1:0]                s_bte;
    logic [DW-1:0]             s_dat_w;
    logic [DW-1:0]             s_dat_r = '0;
    logic                      s_cyc;
    logic                      s_err = 1'b0;
    logic [DW/8-1:0]           s_sel;
    logic                      s_stb;
    logic                      s_ack = 1'b0;
    logic                      s_we;
    logic [N-1:0]              gnt;

    wb_arbiter_rr #(
        .WB_ADDR_WIDTH  (AW),
        .WB_DATA_WIDTH  (DW),
        .N_MASTERS      (N),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .m_adr   (m_adr),
        .m_cti   (m_cti),
        .m_bte   (m_bte),
        .m_dat_w (m_dat_w),
        .m_dat_r (m_dat_r),
        .m_cyc   (m_cyc),
        .m_err   (m_err),
        .m_sel   (m_sel),
        .m_stb   (m_stb),
        .m_ack   (m_ack),
        .m_we    (m_we),
        .s_adr   (s_adr),
        .s_cti   (s_cti),
        .s_bte   (s_bte),
        .s_dat_w (s_dat_w),
        .s_dat_r (s_dat_r),
        .s_cyc   (s_cyc),
        .s_err   (s_err),
        .s_sel   (s_sel),
        .s_stb   (s_stb),
        .s_ack   (s_ack),
        .s_we    (s_we),
        .gnt     (gnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [AW-1:0] adr_of(input int i);
        return 32'h1000 + 32'(i * 16);
    endfunction

    // State shared by the multi-master engine.
    int rem[N];
    int ack_cnt[N];
    int order[$];
    int bad_rsp;
    int gap_err;

    task automatic clear_engine();
        order.delete();
        bad_rsp = 0;
        gap_err = 0;
        for (int i = 0; i < N; i++) begin
            rem[i]     = 0;
            ack_cnt[i] = 0;
            m_adr[i]   = adr_of(i);
        end
    endtask

    // Cycle engine. Each requester performs rem[i] single reads, dropping CYC
    // for one cycle between reads. The slave ACKs one cycle after each strobe
    // and returns ~address as read data.
    task automatic run_engine(input int max_cycles, output bit timed_out);
        logic [N-1:0] g, prev_g, ma;
        logic sc, ss, sa;
        int zero_gap;
        bit seen;
        bit all_done;
        prev_g    = '0;
        zero_gap  = 0;
        seen      = 1'b0;
        timed_out = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            g  = gnt;
            ma = m_ack;
            sc = s_cyc;
            ss = s_stb;
            sa = s_ack;
            if (g != '0 && g != prev_g) begin
                order.push_back(onehot_idx(g));
                if (seen && zero_gap != 1) gap_err++;
                seen     = 1'b1;
                zero_gap = 0;
            end
            if (g == '0) zero_gap++;
            for (int i = 0; i < N; i++) begin
                if (ma[i] && !g[i]) bad_rsp++;
                if (!g[i] && m_dat_r[i] != '0) bad_rsp++;
                if (ma[i]) begin
                    ack_cnt[i]++;
                    if (m_dat_r[i] != ~adr_of(i)) bad_rsp++;
                end
            end
            prev_g   = g;
            all_done = 1'b1;
            for (int i = 0; i < N; i++) if (rem[i] != 0) all_done = 1'b0;
            if (g == '0 && m_cyc == '0 && all_done) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (m_cyc[i] && ma[i]) begin
                    rem[i]--;
                    m_cyc[i] = 1'b0;
                    m_stb[i] = 1'b0;
                end else if (!m_cyc[i] && rem[i] > 0) begin
                    m_cyc[i] = 1'b1;
                    m_stb[i] = 1'b1;
                end
            end
            s_ack   = sc & ss & ~sa;
            s_dat_r = (sc & ss & ~sa) ? ~s_adr : '0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit to;
        int mism;

        // ---- reset values
        #2;
        check("rst_gnt", gnt, 0);
        check("rst_s_cyc", s_cyc, 0);
        check("rst_s_adr", s_adr, 0);
        check("rst_m_ack", m_ack, 0);
        check("rst_m_dat_r", m_dat_r, 0);
        #10 rstn = 1'b1;

        // ---- test 1: m2 single write, slave ACK on the 2nd granted cycle
        @(posedge clk); #1;
        m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_we[2] = 1'b1;
        m_adr[2] = 32'h100; m_dat_w[2] = 32'hA5; m_sel[2] = 4'hF;
        @(negedge clk);
        check("t1_s_cyc_latency", s_cyc, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_s_cyc", s_cyc, 1);
        check("t1_gnt", gnt, 4'b0100);
        check("t1_s_adr", s_adr, 32'h100);
        check("t1_s_dat_w", s_dat_w, 32'hA5);
        check("t1_s_we", s_we, 1);
        check("t1_no_early_ack", m_ack, 0);
        @(posedge clk); #1;
        s_ack = 1'b1;
        @(negedge clk);
        check("t1_ack_fwd", m_ack, 4'b0100);
        @(posedge clk); #1;
        m_cyc[2] = 1'b0; m_stb[2] = 1'b0; m_we[2] = 1'b0; s_ack = 1'b0;
        @(negedge clk);
        check("t1_s_cyc_drop", s_cyc, 0);
        check("t1_single_ack", m_ack, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_gnt_idle", gnt, 0);

        // ---- test 2: all four request together after a fresh reset
        @(posedge clk); #1;
        rstn = 1'b0;
        #3 rstn = 1'b1;
        clear_engine();
        for (int i = 0; i < N; i++) rem[i] = 1;
        run_engine(200, to);
        check("t2_timeout", to, 0);
        check("t2_n_tenures", order.size(), 4);
        for (int k = 0; k < 4; k++) check($sformatf("t2_order%0d", k), order[k], k);
        check("t2_idle_gap", gap_err, 0);
        check("t2_nonowner_rsp", bad_rsp, 0);
        for (int i = 0; i < N; i++) check($sformatf("t2_acks_m%0d", i), ack_cnt[i], 1);

        // ---- test 3: m1 and m3 request repeatedly, 10 transfers each
        clear_engine();
        rem[1] = 10;
        rem[3] = 10;
        run_engine(600, to);
        check("t3_timeout", to, 0);
        check("t3_n_tenures", order.size(), 20);
        mism = 0;
        for (int k = 0; k < order.size(); k++) if (order[k] != ((k % 2 == 0) ? 1 : 3)) mism++;
        check("t3_alternation", mism, 0);
        check("t3_idle_gap", gap_err, 0);
        check("t3_nonowner_rsp", bad_rsp, 0);
        check("t3_acks_m1", ack_cnt[1], 10);
        check("t3_acks_m3", ack_cnt[3], 10);

        // ---- test 4: m0 4-beat incrementing burst, ACK every cycle
        @(posedge clk); #1;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cti[0] = 3'b010; m_bte[0] = 2'b01;
        m_adr[0] = 32'h200;
        @(posedge clk); #1;
        s_ack = 1'b1;
        for (int b = 0; b < 4; b++) begin
            if (b == 3) m_cti[0] = 3'b111;
            @(negedge clk);
            check($sformatf("t4_gnt_b%0d", b), gnt, 4'b0001);
            check($sformatf("t4_cti_b%0d", b), s_cti, (b == 3) ? 3'b111 : 3'b010);
            check($sformatf("t4_bte_b%0d", b), s_bte, 2'b01);
            check($sformatf("t4_adr_b%0d", b), s_adr, 32'h200 + 32'(4 * b));
            check($sformatf("t4_ack_b%0d", b), m_ack, 4'b0001);
            @(posedge clk); #1;
            m_adr[0] = 32'h200 + 32'(4 * (b + 1));
        end
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_cti[0] = 3'b000; s_ack = 1'b0;
        @(negedge clk);
        check("t4_s_cyc_drop", s_cyc, 0);
        check("t4_no_extra_ack", m_ack, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_gnt_idle", gnt, 0);

        // ---- test 5: asynchronous reset in the middle of a burst
        @(posedge clk); #1;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cti[0] = 3'b010;
        @(posedge clk); #1;
        s_ack = 1'b1;
        @(negedge clk);
        check("t5_pre_rst_cyc", s_cyc, 1);
        #2 rstn = 1'b0;
        #1;
        check("t5_async_s_cyc", s_cyc, 0);
        check("t5_async_s_stb", s_stb, 0);
        check("t5_async_gnt", gnt, 0);
        check("t5_no_ack_in_rst", m_ack, 0);
        @(posedge clk); #1;
        s_ack = 1'b0;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        rstn = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_m0_priority", gnt, 4'b0001);
        @(posedge clk); #1;
        m_cyc = '0; m_stb = '0; m_cti = '0; m_bte = '0;
        repeat (3) @(posedge clk);
        #1;

`ifdef WB_ARBITER_TIMEOUT_EN
        // ---- test 6: slave never ACKs, watchdog fires at the 16th stall
        m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
        @(posedge clk); #1;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        mism = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (m_err[2] != (k == 16)) mism++;
            if (!s_cyc) mism++;
            @(posedge clk); #1;
        end
        check("t6_err_timing", mism, 0);
        @(negedge clk);
        check("t6_abort_s_cyc", s_cyc, 0);
        check("t6_abort_err", m_err, 0);
        check("t6_abort_gnt", gnt, 4'b0100);
        @(posedge clk); #1;
        m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_idle", gnt, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_next_owner", gnt, 4'b0010);
        @(posedge clk); #1;
        m_cyc = '0; m_stb = '0;
        repeat (3) @(posedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
